// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: little-endian data memory with byte/half/word access,
// load alignment and extension, and the WB pipeline register with stall/flush.
module mem_wb_stage #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic        StallW,
    input  logic        FlushW,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUOutW,
    output logic [4:0]  WriteRegW,
    output logic        MisalignW
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0]           mem_r [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] index_s;
    logic [31:0]           rd_word_s;
    logic [7:0]            rd_byte_s;
    logic [15:0]           rd_half_s;
    logic [31:0]           rd_ext_s;
    logic                  misalign_s;
    logic                  wr_en_s;
    logic [3:0]            wr_strb_s;
    logic [31:0]           wr_data_s;

    // Upper address bits are dropped so accesses wrap modulo the memory size.
    assign index_s   = ALUOutM[DEPTH_LOG2+1:2];
    assign rd_word_s = mem_r[index_s];
    assign wr_en_s   = MemWriteM & ~misalign_s & ~StallW;

    // Alignment check, only meaningful for actual memory operations.
    always_comb begin
        misalign_s = 1'b0;
        if (MemWriteM | MemtoRegM) begin
            case (MemSizeM)
                2'b00:   misalign_s = 1'b0;
                2'b01:   misalign_s = ALUOutM[0];
                default: misalign_s = (ALUOutM[1:0] != 2'b00);
            endcase
        end else begin
            misalign_s = 1'b0;
        end
    end

    // Lane selection of the read word and sign/zero extension.
    always_comb begin
        rd_byte_s = 8'h00;
        rd_half_s = 16'h0000;
        rd_ext_s  = 32'h0000_0000;
        case (ALUOutM[1:0])
            2'b00:   rd_byte_s = rd_word_s[7:0];
            2'b01:   rd_byte_s = rd_word_s[15:8];
            2'b10:   rd_byte_s = rd_word_s[23:16];
            default: rd_byte_s = rd_word_s[31:24];
        endcase
        if (ALUOutM[1]) begin
            rd_half_s = rd_word_s[31:16];
        end else begin
            rd_half_s = rd_word_s[15:0];
        end
        case (MemSizeM)
            2'b00:   rd_ext_s = MemSignedM ? {{24{rd_byte_s[7]}}, rd_byte_s} : {24'h00_0000, rd_byte_s};
            2'b01:   rd_ext_s = MemSignedM ? {{16{rd_half_s[15]}}, rd_half_s} : {16'h0000, rd_half_s};
            default: rd_ext_s = rd_word_s;
        endcase
    end

    // Byte strobes and lane-replicated store data.
    always_comb begin
        wr_strb_s = 4'b0000;
        wr_data_s = 32'h0000_0000;
        case (MemSizeM)
            2'b00: begin
                wr_strb_s = 4'b0001 << ALUOutM[1:0];
                wr_data_s = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                wr_strb_s = ALUOutM[1] ? 4'b1100 : 4'b0011;
                wr_data_s = {2{WriteDataM[15:0]}};
            end
            default: begin
                wr_strb_s = 4'b1111;
                wr_data_s = WriteDataM;
            end
        endcase
    end

    // WB register plus memory write; the memory is never reset and is only written out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWriteW <= 1'b0;
            MemtoRegW <= 1'b0;
            ReadDataW <= 32'h0000_0000;
            ALUOutW   <= 32'h0000_0000;
            WriteRegW <= 5'd0;
            MisalignW <= 1'b0;
        end else begin
            if (wr_en_s) begin
                for (int i = 0; i < 4; i++) begin
                    if (wr_strb_s[i]) begin
                        mem_r[index_s][8*i +: 8] <= wr_data_s[8*i +: 8];
                    end
                end
            end
            if (FlushW) begin
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
                ReadDataW <= 32'h0000_0000;
                ALUOutW   <= 32'h0000_0000;
                WriteRegW <= 5'd0;
                MisalignW <= 1'b0;
            end else if (!StallW) begin
                RegWriteW <= RegWriteM & ~misalign_s;
                MemtoRegW <= MemtoRegM;
                ReadDataW <= rd_ext_s;
                ALUOutW   <= ALUOutM;
                WriteRegW <= WriteRegM;
                MisalignW <= misalign_s;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        RegWriteM, MemtoRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;
    logic [1:0]  MemSizeM;
    logic        MemSignedM;
    logic        StallW, FlushW;
    logic        RegWriteW, MemtoRegW;
    logic [31:0] ReadDataW, ALUOutW;
    logic [4:0]  WriteRegW;
    logic        MisalignW;

    int checks_r;
    int failures_r;

    mem_wb_stage #(.DEPTH_LOG2(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
        .MemSizeM(MemSizeM), .MemSignedM(MemSignedM),
        .StallW(StallW), .FlushW(FlushW),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
        .ReadDataW(ReadDataW), .ALUOutW(ALUOutW),
        .WriteRegW(WriteRegW), .MisalignW(MisalignW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic m2r, input logic mw,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr, input logic [1:0] sz, input logic sg);
        RegWriteM  = rw;
        MemtoRegM  = m2r;
        MemWriteM  = mw;
        ALUOutM    = alu;
        WriteDataM = wd;
        WriteRegM  = wr;
        MemSizeM   = sz;
        MemSignedM = sg;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks_r   = 0;
        failures_r = 0;
        rst_n  = 1'b0;
        StallW = 1'b0;
        FlushW = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0000_00FF, 32'h0, 5'd3, 2'b10, 1'b0);
        #3;
        check_eq("rst_aluout", ALUOutW, 32'h0);
        check_eq("rst_regwrite", {31'd0, RegWriteW}, 32'h0);
        step();
        check_eq("rst_hold_wreg", {27'd0, WriteRegW}, 32'h0);
        #4 rst_n = 1'b1;

        // Word store then word load
        drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 5'd0, 2'b10, 1'b0);
        step();
        check_eq("st_misalign", {31'd0, MisalignW}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 2'b10, 1'b0);
        step();
        check_eq("ldw_data", ReadDataW, 32'hDEAD_BEEF);
        check_eq("ldw_regwrite", {31'd0, RegWriteW}, 32'h1);
        check_eq("ldw_wreg", {27'd0, WriteRegW}, 32'd5);
        check_eq("ldw_m2r", {31'd0, MemtoRegW}, 32'h1);
        check_eq("ldw_alu", ALUOutW, 32'h10);

        // Sub-word loads with extension
        drive(1'b1, 1'b1, 1'b0, 32'h13, 32'h0, 5'd6, 2'b00, 1'b1);
        step();
        check_eq("lb_signed", ReadDataW, 32'hFFFF_FFDE);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd6, 2'b01, 1'b0);
        step();
        check_eq("lhu", ReadDataW, 32'h0000_BEEF);
        drive(1'b1, 1'b1, 1'b0, 32'h12, 32'h0, 5'd6, 2'b01, 1'b1);
        step();
        check_eq("lh_signed", ReadDataW, 32'hFFFF_DEAD);
        drive(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd6, 2'b00, 1'b0);
        step();
        check_eq("lbu", ReadDataW, 32'h0000_00BE);

        // Byte store with same-cycle read returning the old byte
        drive(1'b0, 1'b1, 1'b1, 32'h11, 32'h1234_565A, 5'd0, 2'b00, 1'b0);
        step();
        check_eq("raw_old", ReadDataW, 32'h0000_00BE);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7, 2'b10, 1'b0);
        step();
        check_eq("sb_result", ReadDataW, 32'hDEAD_5AEF);

        // Half store to upper lanes
        drive(1'b0, 1'b0, 1'b1, 32'h12, 32'hA5A5_7788, 5'd0, 2'b01, 1'b0);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7, 2'b10, 1'b0);
        step();
        check_eq("sh_result", ReadDataW, 32'h7788_5AEF);

        // Misaligned word store: flag for one cycle, memory unchanged
        drive(1'b1, 1'b0, 1'b1, 32'h12, 32'hFFFF_FFFF, 5'd9, 2'b10, 1'b0);
        step();
        check_eq("mis_flag", {31'd0, MisalignW}, 32'h1);
        check_eq("mis_regwrite", {31'd0, RegWriteW}, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7, 2'b10, 1'b0);
        step();
        check_eq("mis_clear", {31'd0, MisalignW}, 32'h0);
        check_eq("mis_regwrite_back", {31'd0, RegWriteW}, 32'h1);
        check_eq("mis_mem_kept", ReadDataW, 32'h7788_5AEF);

        // Misaligned half load; unaligned ALU op without memory access is not flagged
        drive(1'b1, 1'b1, 1'b0, 32'h11, 32'h0, 5'd4, 2'b01, 1'b0);
        step();
        check_eq("mis_lh", {31'd0, MisalignW}, 32'h1);
        drive(1'b1, 1'b0, 1'b0, 32'h13, 32'h0, 5'd4, 2'b10, 1'b0);
        step();
        check_eq("alu_nomis", {31'd0, MisalignW}, 32'h0);
        check_eq("alu_regwrite", {31'd0, RegWriteW}, 32'h1);

        // Address wrap
        drive(1'b1, 1'b1, 1'b0, 32'h410, 32'h0, 5'd8, 2'b10, 1'b0);
        step();
        check_eq("wrap_data", ReadDataW, 32'h7788_5AEF);
        check_eq("wrap_alu", ALUOutW, 32'h410);

        // Stall: outputs hold and a store under stall does not write
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7, 2'b10, 1'b0);
        step();
        check_eq("pre_stall_alu", ALUOutW, 32'h1234);
        StallW = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h0BAD_F00D, 5'd2, 2'b10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_alu", ALUOutW, 32'h1234);
            check_eq("stall_wreg", {27'd0, WriteRegW}, 32'd7);
        end
        StallW = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 5'd7, 2'b10, 1'b0);
        step();
        check_eq("stall_no_write", ReadDataW, 32'h7788_5AEF);

        // Flush overrides stall
        StallW = 1'b1;
        FlushW = 1'b1;
        step();
        check_eq("flush_data", ReadDataW, 32'h0);
        check_eq("flush_alu", ALUOutW, 32'h0);
        check_eq("flush_ctl", {26'd0, WriteRegW, RegWriteW, MemtoRegW, MisalignW} , 32'h0);

        // Flush still lets a qualifying store through
        StallW = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 32'h14, 32'h55AA_55AA, 5'd0, 2'b10, 1'b0);
        step();
        FlushW = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h14, 32'h0, 5'd1, 2'b10, 1'b0);
        step();
        check_eq("flush_store", ReadDataW, 32'h55AA_55AA);

        // Asynchronous reset mid-cycle; memory survives and is not written under reset
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 5'd0, 2'b10, 1'b0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd3, 2'b10, 1'b0);
        step();
        check_eq("pre_rst_alu", ALUOutW, 32'h1234);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_alu", ALUOutW, 32'h0);
        drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h1111_1111, 5'd0, 2'b10, 1'b0);
        step();
        step();
        #3 rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 5'd2, 2'b10, 1'b0);
        step();
        check_eq("post_rst_mem", ReadDataW, 32'hCAFE_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
